// File: rtl/nes_pad_reader_if.sv
// Downstream FIFO write port of the NES pad reader.
interface nes_pad_reader_if;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [15:0] fifo_data;

  modport master (input fifo_full, output fifo_wrreq, output fifo_data);
  modport slave  (output fifo_full, input fifo_wrreq, input fifo_data);
endinterface

// File: rtl/nes_pad_reader.sv
// Polls two NES controllers (4021 shift registers) and pushes {pad1, pad0}
// button bytes into a downstream FIFO, counting words dropped while full.
module nes_pad_reader #(
  parameter int unsigned HALF_DIV = 300,
  parameter int unsigned POLL_DIV = 833333
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     pad0_data,
  input  logic                     pad1_data,
  output logic                     pad_latch,
  output logic                     pad_clk,
  nes_pad_reader_if.master         fifo,
  output logic [15:0]              pad_state,
  output logic [7:0]               drop_count
);

  localparam int unsigned HW = $clog2(2 * HALF_DIV);
  localparam int unsigned PW = $clog2(POLL_DIV);
  localparam logic [HW-1:0] LATCH_LEN   = HW'(2 * HALF_DIV - 1);
  localparam logic [HW-1:0] HALF_LEN    = HW'(HALF_DIV - 1);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_DIV - 1);

  typedef enum logic [2:0] {IDLE, LATCH, BIT_LO, BIT_HI, PUSH} state_e;

  state_e        state_q;
  logic [1:0]    sync0_q, sync1_q;
  logic [PW-1:0] poll_q;
  logic [HW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh0_q, sh1_q;
  logic          latch_q, clk_q;
  logic [15:0]   data_q, pad_state_q;
  logic [7:0]    drop_q;

  logic          poll_start;
  logic [7:0]    sh0_d, sh1_d;

  assign poll_start = (poll_q == '0);
  // Pads are active-low; invert after synchronizing so pressed reads as 1.
  assign sh0_d      = {sh0_q[6:0], ~sync0_q[1]};
  assign sh1_d      = {sh1_q[6:0], ~sync1_q[1]};

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync0_q     <= '1;
      sync1_q     <= '1;
      poll_q      <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      latch_q     <= 1'b0;
      clk_q       <= 1'b0;
      data_q      <= '0;
      pad_state_q <= '0;
      drop_q      <= '0;
    end else begin
      sync0_q <= {sync0_q[0], pad0_data};
      sync1_q <= {sync1_q[0], pad1_data};
      poll_q  <= poll_start ? POLL_RELOAD : poll_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (poll_start) begin
            state_q <= LATCH;
            cnt_q   <= LATCH_LEN;
            bit_q   <= '0;
            latch_q <= 1'b1;
          end
        end
        LATCH: begin
          if (cnt_q == '0) begin
            state_q <= BIT_LO;
            cnt_q   <= HALF_LEN;
            latch_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BIT_LO: begin
          if (cnt_q == '0) begin
            sh0_q <= sh0_d;
            sh1_q <= sh1_d;
            if (bit_q == 3'd7) begin
              // Word is loaded on PUSH entry so it is already valid with the strobe.
              state_q <= PUSH;
              data_q  <= {sh1_d, sh0_d};
            end else begin
              state_q <= BIT_HI;
              cnt_q   <= HALF_LEN;
              clk_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BIT_HI: begin
          if (cnt_q == '0) begin
            state_q <= BIT_LO;
            cnt_q   <= HALF_LEN;
            clk_q   <= 1'b0;
            bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PUSH: begin
          state_q     <= IDLE;
          pad_state_q <= {sh1_q, sh0_q};
          if (fifo.fifo_full && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pad_latch       = latch_q;
  assign pad_clk         = clk_q;
  assign fifo.fifo_wrreq = (state_q == PUSH) && !fifo.fifo_full;
  assign fifo.fifo_data  = data_q;
  assign pad_state       = pad_state_q;
  assign drop_count      = drop_q;

endmodule
